// File: rtl/fir_result_fifo.sv
// Result capture FIFO behind fir_filter: a modwait falling edge queues {err, fir_out}
// into a show-ahead FIFO with count/full/empty status and a sticky overflow flag.
module fir_result_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_BITS  = 3
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  modwait,
  input  logic [DATA_WIDTH-1:0] fir_out,
  input  logic                  err,
  input  logic                  read_en,
  input  logic                  clear_overflow,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_err,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_BITS:0]    count,
  output logic                  overflow
);

  localparam logic [ADDR_BITS-1:0] PtrOne   = ADDR_BITS'(1);
  localparam logic [ADDR_BITS:0]   CountOne = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS:0]   CountMax = (ADDR_BITS + 1)'(DEPTH);

  logic                  modwait_q;
  logic                  capture_pending_q, capture_pending_d;
  logic [ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]    count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH:0]   mem_q [DEPTH];

  logic fall_edge;
  logic do_pop;
  logic do_write;

  assign empty = (count_q == '0);
  assign full  = (count_q == CountMax);
  assign count = count_q;
  assign overflow = overflow_q;

  assign fall_edge = modwait_q & ~modwait;
  assign do_pop    = read_en & ~empty;
  // A full FIFO still accepts the write when a pop frees the head slot in the same cycle.
  assign do_write  = capture_pending_q & (~full | do_pop);

  assign read_data = empty ? '0 : mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign read_err  = empty ? 1'b0 : mem_q[rd_ptr_q][DATA_WIDTH];

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    capture_pending_d = capture_pending_q;
    wr_ptr_d          = wr_ptr_q;
    rd_ptr_d          = rd_ptr_q;
    count_d           = count_q;
    overflow_d        = overflow_q;

    if (capture_pending_q) begin
      capture_pending_d = 1'b0;
    end else if (fall_edge) begin
      capture_pending_d = 1'b1;
    end

    if (do_write) wr_ptr_d = wr_ptr_q + PtrOne;
    if (do_pop)   rd_ptr_d = rd_ptr_q + PtrOne;

    unique case ({do_write, do_pop})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase

    if (clear_overflow) overflow_d = 1'b0;
    if (capture_pending_q && !do_write) overflow_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      modwait_q         <= 1'b0;
      capture_pending_q <= 1'b0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      overflow_q        <= 1'b0;
    end else begin
      modwait_q         <= modwait;
      capture_pending_q <= capture_pending_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      count_q           <= count_d;
      overflow_q        <= overflow_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; stale entries are never visible
  // because the read path is gated by empty.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= {err, fir_out};
  end

endmodule

// File: tb/tb_fir_result_fifo.sv
// Scoreboard bench for fir_result_fifo: captured results are queued in a model FIFO
// and compared against the show-ahead head on every pop.
module tb_fir_result_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AB    = 3;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          modwait;
  logic [DW-1:0] fir_out;
  logic          err;
  logic          read_en;
  logic          clear_overflow;
  logic [DW-1:0] read_data;
  logic          read_err;
  logic          empty;
  logic          full;
  logic [AB:0]   count;
  logic          overflow;

  fir_result_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_BITS(AB)) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .modwait        (modwait),
    .fir_out        (fir_out),
    .err            (err),
    .read_en        (read_en),
    .clear_overflow (clear_overflow),
    .read_data      (read_data),
    .read_err       (read_err),
    .empty          (empty),
    .full           (full),
    .count          (count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW:0] sb_q [$];
  logic        ovf_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag);
    if (sb_q.size() == 0) begin
      check({tag, "_empty"}, 32'(empty), 32'd1);
      check({tag, "_data0"}, 32'(read_data), 32'd0);
      check({tag, "_err0"}, 32'(read_err), 32'd0);
    end else begin
      check({tag, "_data"}, 32'(read_data), 32'(sb_q[0][DW-1:0]));
      check({tag, "_err"}, 32'(read_err), 32'(sb_q[0][DW]));
    end
  endtask

  // Full modwait busy/done cycle; the write lands at the 2nd edge after modwait falls.
  task automatic capture(input logic [DW-1:0] val, input logic e, input logic pop_at_write);
    int cnt_before;
    cnt_before = sb_q.size();
    modwait = 1'b1;
    repeat (4) tick();
    modwait = 1'b0;
    fir_out = val;
    err     = e;
    tick();
    check("latency_cnt", 32'(count), 32'(cnt_before));
    if (pop_at_write) begin
      check_head("pop_w_write");
      read_en = 1'b1;
    end
    tick();
    read_en = 1'b0;
    if (pop_at_write && sb_q.size() > 0) void'(sb_q.pop_front());
    if (sb_q.size() < DEPTH) sb_q.push_back({e, val});
    else ovf_exp = 1'b1;
    check("cap_count", 32'(count), 32'(sb_q.size()));
    check("cap_ovf", 32'(overflow), 32'(ovf_exp));
    check("cap_full", 32'(full), 32'(sb_q.size() == DEPTH));
  endtask

  task automatic pop();
    check_head("pop");
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    check("pop_count", 32'(count), 32'(sb_q.size()));
  endtask

  initial begin
    n_reset        = 1'b0;
    modwait        = 1'b0;
    fir_out        = '0;
    err            = 1'b0;
    read_en        = 1'b0;
    clear_overflow = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    tick();

    // Reset state
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_data", 32'(read_data), 32'd0);
    check("rst_err", 32'(read_err), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // Single capture and pop
    capture(16'd50, 1'b0, 1'b0);
    check_head("single");
    pop();
    check("single_empty", 32'(empty), 32'd1);
    check("single_data0", 32'(read_data), 32'd0);

    // Fill, overflow, drain, clear
    for (int i = 1; i <= 8; i++) capture(DW'(i), 1'b0, 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd8);
    capture(16'd9, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) pop();
    check("drain_empty", 32'(empty), 32'd1);
    check("ovf_sticky", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    ovf_exp = 1'b0;
    check("ovf_clear", 32'(overflow), 32'd0);

    // Write and pop on the same edge while full; pointers wrap
    for (int i = 1; i <= 8; i++) capture(DW'(i), 1'b0, 1'b0);
    capture(16'd9, 1'b0, 1'b1);
    check("wp_count", 32'(count), 32'd8);
    check("wp_ovf", 32'(overflow), 32'd0);
    check("wp_head", 32'(read_data), 32'd2);
    for (int i = 0; i < 8; i++) pop();
    check("wp_empty", 32'(empty), 32'd1);

    // Error bit and all-ones data, then reads while empty
    capture(16'hFFFF, 1'b1, 1'b0);
    check("err_bit", 32'(read_err), 32'd1);
    check("err_data", 32'(read_data), 32'hFFFF);
    pop();
    read_en = 1'b1;
    repeat (3) begin
      tick();
      check("rd_empty_cnt", 32'(count), 32'd0);
    end
    read_en = 1'b0;
    capture(16'h1234, 1'b0, 1'b0);
    check_head("after_empty_rd");
    pop();

    // Same-edge write and pop while empty: pop ignored
    capture(16'h00A5, 1'b1, 1'b1);
    check("ept_wp_count", 32'(count), 32'd1);
    check_head("ept_wp");
    pop();

    // Asynchronous reset with a capture pending
    for (int i = 0; i < 3; i++) capture(DW'(16'h100 + i), 1'b0, 1'b0);
    modwait = 1'b1;
    repeat (4) tick();
    modwait = 1'b0;
    fir_out = 16'hBEEF;
    tick();
    #2;
    n_reset = 1'b0;
    #1;
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_count", 32'(count), 32'd0);
    check("arst_data", 32'(read_data), 32'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    repeat (3) begin
      tick();
      check("arst_nowrite", 32'(count), 32'd0);
    end
    capture(16'h0777, 1'b0, 1'b0);
    check_head("post_rst");
    pop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
